// File: rtl/fc_pkg.sv
// Shared constants, state encoding and helpers for the fully-connected stage.
// Holds IN_NUM/OUT_NUM/ACC_W defaults and the i/o counter widths.
package fc_pkg;

  localparam int FC_IN_NUM  = 27;
  localparam int FC_OUT_NUM = 10;
  localparam int FC_ACC_W   = 24;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FC_I_W = cnt_w(FC_IN_NUM);
  localparam int FC_O_W = cnt_w(FC_OUT_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fc_state_t;

endpackage

// File: rtl/fc_mac.sv
// Shared multiply-accumulate: unsigned 8-bit activation times signed 8-bit
// weight added into a registered ACC_W accumulator; load overrides accumulate.
// Ports: clk, rst, en, load, x, w, load_val in; acc (registered), sum (acc+prod) out.
module fc_mac
  import fc_pkg::*;
#(
  parameter int ACC_W = FC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [7:0]              x,
  input  logic signed [7:0]       w,
  input  logic signed [ACC_W-1:0] load_val,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [8:0]       xs;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;

  // x is unsigned, so a zero MSB makes the 9x8 product signed-correct.
  assign xs       = $signed({1'b0, x});
  assign prod     = xs * w;
  assign prod_ext = {{(ACC_W-17){prod[16]}}, prod};
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fc_module.sv
// Fully-connected classifier: latches pooled vector, runs one MAC per cycle
// over IN_NUM x OUT_NUM weights plus bias, presents results on valid/ready.
// Ports: clk, rst, pool_lin/in_valid/in_ready, weight_lin, bias_lin,
// fc_lin/out_valid/out_ready. Optional ReLU clamp: define FC_RELU_EN.
module fc_module
  import fc_pkg::*;
#(
  parameter int IN_NUM  = FC_IN_NUM,
  parameter int OUT_NUM = FC_OUT_NUM,
  parameter int ACC_W   = FC_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_NUM*8-1:0]        pool_lin,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OUT_NUM*IN_NUM*8-1:0] weight_lin,
  input  logic [OUT_NUM*8-1:0]       bias_lin,
  output logic [OUT_NUM*ACC_W-1:0]   fc_lin,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int I_W = cnt_w(IN_NUM);
  localparam int O_W = cnt_w(OUT_NUM);

  localparam logic [I_W-1:0] I_LAST = I_W'(IN_NUM - 1);
  localparam logic [O_W-1:0] O_LAST = O_W'(OUT_NUM - 1);

  fc_state_t state;

  logic [I_W-1:0]      i;
  logic [O_W-1:0]      o;
  logic [IN_NUM*8-1:0] x_reg;

  logic signed [ACC_W-1:0] res [OUT_NUM];

  logic [7:0]              x_cur;
  logic signed [7:0]       w_cur;
  logic [7:0]              b_sel;
  logic signed [ACC_W-1:0] b_ext;
  logic                    mac_en;
  logic                    mac_load;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] wr_val;
  logic                    hs_in;
  logic                    last_i;
  int                      x_idx;
  int                      w_idx;
  int                      b_idx;

  assign hs_in  = in_valid && in_ready;
  assign last_i = (i == I_LAST);

  always_comb begin
    x_idx = int'(i) * 8;
    w_idx = (int'(o) * IN_NUM + int'(i)) * 8;
    x_cur = x_reg[x_idx +: 8];
    w_cur = $signed(weight_lin[w_idx +: 8]);
  end

  // Bias for the accumulator preload: b[0] at handshake, b[o+1] after each
  // neuron. Past the last neuron the preload is unused, so select b[0].
  always_comb begin
    b_idx = 0;
    if (state == MAC && o != O_LAST) begin
      b_idx = (int'(o) + 1) * 8;
    end
    b_sel = bias_lin[b_idx +: 8];
    b_ext = {{(ACC_W-8){b_sel[7]}}, b_sel};
  end

  assign mac_en   = (state == MAC);
  assign mac_load = hs_in || (mac_en && last_i);

  fc_mac #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en      (mac_en),
    .load    (mac_load),
    .x       (x_cur),
    .w       (w_cur),
    .load_val(b_ext),
    .acc     (acc),
    .sum     (sum)
  );

  always_comb begin
    wr_val = sum;
`ifdef FC_RELU_EN
    if (sum[ACC_W-1]) begin
      wr_val = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      o         <= '0;
      x_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int k = 0; k < OUT_NUM; k++) begin
        res[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= pool_lin;
            i        <= '0;
            o        <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (last_i) begin
            res[o] <= wr_val;
            i      <= '0;
            if (o == O_LAST) begin
              o         <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              o <= o + O_W'(1);
            end
          end else begin
            i <= i + I_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fc_lin = '0;
    for (int k = 0; k < OUT_NUM; k++) begin
      fc_lin[k*ACC_W +: ACC_W] = res[k];
    end
  end

endmodule

// File: tb/tb_fc_module.sv
// Self-checking bench for fc_module: directed runs with a result scoreboard.
// Covers reset, uniform/extreme patterns, backpressure, mid-run reset, back-to-back.
module tb_fc_module;
  import fc_pkg::*;

  localparam int IN_NUM  = FC_IN_NUM;
  localparam int OUT_NUM = FC_OUT_NUM;
  localparam int ACC_W   = FC_ACC_W;
  localparam int VW      = OUT_NUM * ACC_W;
  localparam int LAT     = IN_NUM * OUT_NUM + 1;
  localparam int BUDGET  = 1000;

  typedef logic [VW-1:0] vec_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [IN_NUM*8-1:0]         pool_lin;
  logic                        in_valid;
  logic                        in_ready;
  logic [OUT_NUM*IN_NUM*8-1:0] weight_lin;
  logic [OUT_NUM*8-1:0]        bias_lin;
  logic [VW-1:0]               fc_lin;
  logic                        out_valid;
  logic                        out_ready;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   lat;
  vec_t q [$];

  fc_module dut (
    .clk       (clk),
    .rst       (rst),
    .pool_lin  (pool_lin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight_lin(weight_lin),
    .bias_lin  (bias_lin),
    .fc_lin    (fc_lin),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic vec_t model();
    vec_t r = '0;
    for (int o = 0; o < OUT_NUM; o++) begin
      logic signed [7:0] bv;
      int s;
      bv = bias_lin[o*8 +: 8];
      s  = int'(bv);
      for (int i = 0; i < IN_NUM; i++) begin
        logic [7:0]        xv;
        logic signed [7:0] wv;
        xv = pool_lin[i*8 +: 8];
        wv = weight_lin[(o*IN_NUM+i)*8 +: 8];
        s += int'(xv) * int'(wv);
      end
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      r[o*ACC_W +: ACC_W] = ACC_W'(s);
    end
    return r;
  endfunction

  task automatic set_all(input int x, input int w, input int b);
    for (int i = 0; i < IN_NUM; i++) pool_lin[i*8 +: 8] = 8'(x);
    for (int k = 0; k < IN_NUM*OUT_NUM; k++) weight_lin[k*8 +: 8] = 8'(w);
    for (int o = 0; o < OUT_NUM; o++) bias_lin[o*8 +: 8] = 8'(b);
  endtask

  task automatic handshake();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < BUDGET) begin
      cycle();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", vec_t'(in_ready), vec_t'(1));
    hs_cyc = cyc;
    q.push_back(model());
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    int n = 0;
    while (!out_valid && n < BUDGET) begin
      cycle();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", vec_t'(out_valid), vec_t'(1));
    l = cyc - hs_cyc;
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed=unexpected_output expected=none", tag);
    end else begin
      chk(tag, fc_lin, q.pop_front());
    end
  endtask

  task automatic collect(input string tag);
    pop_chk(tag);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, vec_t'(in_ready), vec_t'(1));
    chk({tag, "_out_valid_after"}, vec_t'(out_valid), vec_t'(0));
  endtask

  initial begin
    vec_t snap;
    int   hs1;
    int   hs2;
    bit   got;
    logic [ACC_W-1:0] n3_exp;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_all(0, 0, 0);
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
    chk("rst_fc_lin", fc_lin, vec_t'(0));

    // All ones: every neuron sums to IN_NUM.
    set_all(1, 1, 0);
    handshake();
    wait_valid(lat);
    chk("ones_latency", vec_t'(lat), vec_t'(LAT));
    chk("ones_n0", vec_t'(fc_lin[ACC_W-1:0]), vec_t'(27));
    collect("ones_result");

    // Extreme negative on neuron 3 only.
    set_all(255, 0, 0);
    for (int i = 0; i < IN_NUM; i++) weight_lin[(3*IN_NUM+i)*8 +: 8] = 8'h80;
    bias_lin[3*8 +: 8] = 8'h80;
`ifdef FC_RELU_EN
    n3_exp = '0;
`else
    n3_exp = -24'sd881408;
`endif
    handshake();
    wait_valid(lat);
    chk("neg_latency", vec_t'(lat), vec_t'(LAT));
    chk("neg_n3", vec_t'(fc_lin[3*ACC_W +: ACC_W]), vec_t'(n3_exp));
    collect("neg_result");

    // Random data, then backpressure with a pending new input.
    for (int i = 0; i < IN_NUM; i++) pool_lin[i*8 +: 8] = 8'($urandom);
    for (int k = 0; k < IN_NUM*OUT_NUM; k++) weight_lin[k*8 +: 8] = 8'($urandom);
    for (int o = 0; o < OUT_NUM; o++) bias_lin[o*8 +: 8] = 8'($urandom);
    handshake();
    wait_valid(lat);
    chk("rand_latency", vec_t'(lat), vec_t'(LAT));
    snap = q[0];
    for (int i = 0; i < IN_NUM; i++) pool_lin[i*8 +: 8] = 8'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      chk("bp_stable", fc_lin, snap);
      chk("bp_in_ready", vec_t'(in_ready), vec_t'(0));
      chk("bp_out_valid", vec_t'(out_valid), vec_t'(1));
      cycle();
    end
    collect("bp_result");
    handshake();
    wait_valid(lat);
    chk("bp_next_latency", vec_t'(lat), vec_t'(LAT));
    collect("bp_next_result");

    // Reset in the middle of a run.
    set_all(7, -3, 1);
    handshake();
    while (cyc < hs_cyc + 100) cycle();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("midrst_out_valid", vec_t'(out_valid), vec_t'(0));
    chk("midrst_fc_lin", fc_lin, vec_t'(0));
    q.delete();
    cycle();
    rst = 1'b0;
    cycle();
    set_all(2, 3, 5);
    handshake();
    wait_valid(lat);
    chk("post_rst_latency", vec_t'(lat), vec_t'(LAT));
    chk("post_rst_n9", vec_t'(fc_lin[9*ACC_W +: ACC_W]), vec_t'(167));
    collect("post_rst_result");

    // Back-to-back with out_ready tied high; only pool differs.
    for (int i = 0; i < IN_NUM; i++) pool_lin[i*8 +: 8] = 8'(i * 9);
    out_ready = 1'b1;
    handshake();
    hs1 = hs_cyc;
    hs2 = 0;
    got = 1'b0;
    for (int i = 0; i < IN_NUM; i++) pool_lin[i*8 +: 8] = 8'(200 - i);
    in_valid = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      if (out_valid) begin
        pop_chk("b2b_first");
        got = 1'b1;
      end
      if (in_ready) begin
        hs2 = cyc;
        q.push_back(model());
        cycle();
        break;
      end
      cycle();
    end
    in_valid = 1'b0;
    chk("b2b_got_first", vec_t'(got), vec_t'(1));
    chk("b2b_spacing", vec_t'(hs2 - hs1), vec_t'(LAT + 1));
    hs_cyc = hs2;
    wait_valid(lat);
    chk("b2b_latency", vec_t'(lat), vec_t'(LAT));
    collect("b2b_second");
    chk("queue_empty", vec_t'(q.size()), vec_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
